// File: rtl/multi_zone_air_conditioner_if.sv
// Bus bundle for the multi-zone air conditioner: setpoint/sensor inputs and
// per-zone regulated temperature, mode and at-target outputs.
interface multi_zone_air_conditioner_if #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned ZONES = 2
);
   logic                     en;
   logic [ZONES-1:0]         load;
   logic [ZONES*WIDTH-1:0]   temp_in;
   logic [ZONES*WIDTH-1:0]   ideal;
   logic [ZONES*WIDTH-1:0]   out_temp;
   logic [2*ZONES-1:0]       mode;
   logic [ZONES-1:0]         at_target;

   modport master (
      output en, load, temp_in, ideal,
      input  out_temp, mode, at_target
   );

   modport slave (
      input  en, load, temp_in, ideal,
      output out_temp, mode, at_target
   );
endinterface

// File: rtl/multi_zone_air_conditioner.sv
// ZONES independent temperature regulators, each an IDLE/HEAT/COOL stepper with
// hysteresis and a settle counter feeding a registered at-target flag.
module multi_zone_air_conditioner #(
   parameter int unsigned WIDTH  = 6,
   parameter int unsigned ZONES  = 2,
   parameter int unsigned STEP   = 1,
   parameter int unsigned HYST   = 1,
   parameter int unsigned SETTLE = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   multi_zone_air_conditioner_if.slave bus
);

   localparam int unsigned XW = WIDTH + 1;
   localparam int unsigned CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam logic [XW-1:0] STEP_X = XW'(STEP);
   localparam logic [XW-1:0] HYST_X = XW'(HYST);
   localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HEAT = 2'b01,
      COOL = 2'b10
   } state_e;

   for (genvar z = 0; z < ZONES; z++) begin : g_zone
      state_e           mode_q, mode_d;
      logic [WIDTH-1:0] cur_q, cur_d;
      logic [WIDTH-1:0] ideal_z;
      logic [CW-1:0]    cnt_q, cnt_d;
      logic             at_q;
      logic [XW-1:0]    cur_x, ideal_x, gap_up, gap_dn;
      logic             heat_req, cool_req;

      // Widened compares so ideal+HYST and cur+STEP never wrap.
      assign ideal_z  = bus.ideal[z*WIDTH +: WIDTH];
      assign cur_x    = XW'(cur_q);
      assign ideal_x  = XW'(ideal_z);
      assign heat_req = ideal_x > (cur_x + HYST_X);
      assign cool_req = cur_x > (ideal_x + HYST_X);
      assign gap_up   = ideal_x - cur_x;
      assign gap_dn   = cur_x - ideal_x;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            mode_q <= IDLE;
            cur_q  <= '0;
            cnt_q  <= '0;
            at_q   <= 1'b0;
         end else begin
            mode_q <= mode_d;
            cur_q  <= cur_d;
            cnt_q  <= cnt_d;
            at_q   <= (cnt_d == SETTLE_C);
         end
      end

      always_comb begin
         mode_d = mode_q;
         cur_d  = cur_q;
         cnt_d  = cnt_q;
         if (bus.load[z]) begin
            cur_d  = bus.temp_in[z*WIDTH +: WIDTH];
            mode_d = IDLE;
            cnt_d  = '0;
         end else if (bus.en) begin
            case (mode_q)
               IDLE: begin
                  if (heat_req)      mode_d = HEAT;
                  else if (cool_req) mode_d = COOL;
               end
               HEAT: begin
                  if (cur_x >= ideal_x) mode_d = IDLE;
                  else if (gap_up > STEP_X) cur_d = WIDTH'(cur_x + STEP_X);
                  else cur_d = ideal_z;
               end
               COOL: begin
                  if (cur_x <= ideal_x) mode_d = IDLE;
                  else if (gap_dn > STEP_X) cur_d = WIDTH'(cur_x - STEP_X);
                  else cur_d = ideal_z;
               end
               default: mode_d = IDLE;
            endcase
            // Settle only counts while the registered mode is IDLE and in band.
            if (mode_q == IDLE && !heat_req && !cool_req)
               cnt_d = (cnt_q == SETTLE_C) ? cnt_q : cnt_q + CW'(1);
            else
               cnt_d = '0;
         end
      end

      assign bus.out_temp[z*WIDTH +: WIDTH] = cur_q;
      assign bus.mode[2*z +: 2]             = mode_q;
      assign bus.at_target[z]               = at_q;
   end

endmodule

// File: tb/tb_multi_zone_air_conditioner.sv
// Directed bench: per-cycle vector table plus hand sequences for reversal,
// enable freeze, mid-ramp reload/reset and a STEP=4 instance.
module tb_multi_zone_air_conditioner;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   multi_zone_air_conditioner_if #(.WIDTH(6), .ZONES(2)) a_if ();
   multi_zone_air_conditioner_if #(.WIDTH(6), .ZONES(2)) b_if ();

   multi_zone_air_conditioner #(.WIDTH(6), .ZONES(2), .STEP(1), .HYST(1), .SETTLE(4))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));

   multi_zone_air_conditioner #(.WIDTH(6), .ZONES(2), .STEP(4), .HYST(1), .SETTLE(4))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        en;
      logic [1:0]  load;
      logic [11:0] temp_in;
      logic [11:0] ideal;
      logic [11:0] exp_out;
      logic [3:0]  exp_mode;
      logic [1:0]  exp_at;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [11:0] p2(input logic [5:0] hi, input logic [5:0] lo);
      return {hi, lo};
   endfunction

   function automatic void add(input logic r, input logic e, input logic [1:0] ld,
                               input logic [11:0] ti, input logic [11:0] id,
                               input logic [11:0] eo, input logic [3:0] em,
                               input logic [1:0] ea);
      vec_t v;
      v.rst_n = r; v.en = e; v.load = ld; v.temp_in = ti; v.ideal = id;
      v.exp_out = eo; v.exp_mode = em; v.exp_at = ea;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] prev_mode;

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b1;
      a_if.en = 1'b1; a_if.load = 2'b00; a_if.temp_in = '0; a_if.ideal = '0;
      b_if.en = 1'b1; b_if.load = 2'b00; b_if.temp_in = '0; b_if.ideal = '0;

      // Reset held two edges with load asserted and nonzero temp_in.
      add(1'b0, 1'b1, 2'b11, p2(6'd40, 6'd33), p2(6'd0, 6'd0), p2(6'd0, 6'd0), 4'b0000, 2'b00);
      add(1'b0, 1'b1, 2'b11, p2(6'd40, 6'd33), p2(6'd0, 6'd0), p2(6'd0, 6'd0), 4'b0000, 2'b00);
      for (int k = 1; k <= 4; k++)
         add(1'b1, 1'b1, 2'b00, p2(6'd40, 6'd33), p2(6'd0, 6'd0), p2(6'd0, 6'd0), 4'b0000,
             (k == 4) ? 2'b11 : 2'b00);
      // Zone 0 heats 17->27; zone 1 loaded at 21 within hysteresis of 20.
      add(1'b1, 1'b1, 2'b11, p2(6'd21, 6'd17), p2(6'd20, 6'd27), p2(6'd21, 6'd17), 4'b0000, 2'b00);
      add(1'b1, 1'b1, 2'b00, p2(6'd21, 6'd17), p2(6'd20, 6'd27), p2(6'd21, 6'd17), 4'b0001, 2'b00);
      for (int k = 2; k <= 11; k++)
         add(1'b1, 1'b1, 2'b00, p2(6'd21, 6'd17), p2(6'd20, 6'd27),
             p2(6'd21, 6'(17 + k - 1)), 4'b0001, (k >= 4) ? 2'b10 : 2'b00);
      for (int k = 12; k <= 16; k++)
         add(1'b1, 1'b1, 2'b00, p2(6'd21, 6'd17), p2(6'd20, 6'd27),
             p2(6'd21, 6'd27), 4'b0000, (k == 16) ? 2'b11 : 2'b10);
      // Zone 1 setpoint raised out of band: heat to 23.
      add(1'b1, 1'b1, 2'b00, p2(6'd21, 6'd17), p2(6'd23, 6'd27), p2(6'd21, 6'd27), 4'b0100, 2'b01);
      add(1'b1, 1'b1, 2'b00, p2(6'd21, 6'd17), p2(6'd23, 6'd27), p2(6'd22, 6'd27), 4'b0100, 2'b01);
      add(1'b1, 1'b1, 2'b00, p2(6'd21, 6'd17), p2(6'd23, 6'd27), p2(6'd23, 6'd27), 4'b0100, 2'b01);
      add(1'b1, 1'b1, 2'b00, p2(6'd21, 6'd17), p2(6'd23, 6'd27), p2(6'd23, 6'd27), 4'b0000, 2'b01);

      #2;
      foreach (tbl[i]) begin
         rst_n        = tbl[i].rst_n;
         a_if.en      = tbl[i].en;
         a_if.load    = tbl[i].load;
         a_if.temp_in = tbl[i].temp_in;
         a_if.ideal   = tbl[i].ideal;
         tick();
         chk($sformatf("vec%0d_out_temp", i), 32'(a_if.out_temp), 32'(tbl[i].exp_out));
         chk($sformatf("vec%0d_mode", i), 32'(a_if.mode), 32'(tbl[i].exp_mode));
         chk($sformatf("vec%0d_at_target", i), 32'(a_if.at_target), 32'(tbl[i].exp_at));
      end

      // Setpoint reversal on zone 0: heat to 22, drop ideal to 15.
      a_if.load = 2'b01; a_if.temp_in[5:0] = 6'd17; a_if.ideal[5:0] = 6'd27;
      tick();
      chk("rev_load_out", 32'(a_if.out_temp[5:0]), 32'd17);
      a_if.load = 2'b00;
      prev_mode = a_if.mode[1:0];
      tick();
      chk("rev_heat_mode", 32'(a_if.mode[1:0]), 32'd1);
      prev_mode = a_if.mode[1:0];
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("rev_ramp%0d", i), 32'(a_if.out_temp[5:0]), 32'(18 + i));
         prev_mode = a_if.mode[1:0];
      end
      a_if.ideal[5:0] = 6'd15;
      tick();
      chk("rev_idle_mode", 32'(a_if.mode[1:0]), 32'd0);
      chk("rev_idle_out", 32'(a_if.out_temp[5:0]), 32'd22);
      prev_mode = a_if.mode[1:0];
      tick();
      chk("rev_cool_mode", 32'(a_if.mode[1:0]), 32'd2);
      chk("rev_no_heat_to_cool", 32'(prev_mode == 2'b01 && a_if.mode[1:0] == 2'b10), 32'd0);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk($sformatf("rev_cool%0d", i), 32'(a_if.out_temp[5:0]), 32'(21 - i));
      end
      tick();
      chk("rev_end_mode", 32'(a_if.mode[1:0]), 32'd0);
      chk("rev_end_out", 32'(a_if.out_temp[5:0]), 32'd15);

      // Enable freeze mid-ramp; zone 1 settle count must freeze too.
      a_if.load = 2'b01; a_if.temp_in[5:0] = 6'd17; a_if.ideal[5:0] = 6'd27;
      tick();
      a_if.load = 2'b00;
      tick();
      chk("frz_heat_mode", 32'(a_if.mode[1:0]), 32'd1);
      a_if.load = 2'b10; a_if.temp_in[11:6] = 6'd30; a_if.ideal[11:6] = 6'd30;
      tick();
      chk("frz_ramp18", 32'(a_if.out_temp[5:0]), 32'd18);
      a_if.load = 2'b00;
      tick();
      tick();
      chk("frz_ramp20", 32'(a_if.out_temp[5:0]), 32'd20);
      a_if.en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("frz_hold_out%0d", i), 32'(a_if.out_temp[5:0]), 32'd20);
         chk($sformatf("frz_hold_mode%0d", i), 32'(a_if.mode[1:0]), 32'd1);
         chk($sformatf("frz_hold_at1_%0d", i), 32'(a_if.at_target[1]), 32'd0);
      end
      a_if.en = 1'b1;
      tick();
      chk("frz_resume21", 32'(a_if.out_temp[5:0]), 32'd21);
      chk("frz_resume_at1", 32'(a_if.at_target[1]), 32'd0);
      tick();
      chk("frz_ramp22", 32'(a_if.out_temp[5:0]), 32'd22);
      chk("frz_settled_at1", 32'(a_if.at_target[1]), 32'd1);

      // Reload mid-ramp, then reset mid-ramp.
      a_if.load = 2'b01; a_if.temp_in[5:0] = 6'd5;
      tick();
      chk("reload_out", 32'(a_if.out_temp[5:0]), 32'd5);
      chk("reload_mode", 32'(a_if.mode[1:0]), 32'd0);
      a_if.load = 2'b00;
      tick();
      chk("reload_heat", 32'(a_if.mode[1:0]), 32'd1);
      tick();
      chk("reload_ramp6", 32'(a_if.out_temp[5:0]), 32'd6);
      rst_n = 1'b0;
      tick();
      chk("midrst_out", 32'(a_if.out_temp), 32'd0);
      chk("midrst_mode", 32'(a_if.mode), 32'd0);
      chk("midrst_at", 32'(a_if.at_target), 32'd0);
      rst_n = 1'b1;

      // STEP=4: zone 1 cools 30->10, zone 0 heats 17->27 with saturation.
      b_if.load = 2'b11; b_if.temp_in = p2(6'd30, 6'd17); b_if.ideal = p2(6'd10, 6'd27);
      tick();
      chk("s4_load_out", 32'(b_if.out_temp), 32'(p2(6'd30, 6'd17)));
      b_if.load = 2'b00;
      tick();
      chk("s4_mode_start", 32'(b_if.mode), 32'b1001);
      tick();
      chk("s4_out2", 32'(b_if.out_temp), 32'(p2(6'd26, 6'd21)));
      tick();
      chk("s4_out3", 32'(b_if.out_temp), 32'(p2(6'd22, 6'd25)));
      tick();
      chk("s4_out4", 32'(b_if.out_temp), 32'(p2(6'd18, 6'd27)));
      chk("s4_mode4", 32'(b_if.mode), 32'b1001);
      tick();
      chk("s4_out5", 32'(b_if.out_temp), 32'(p2(6'd14, 6'd27)));
      chk("s4_mode5", 32'(b_if.mode), 32'b1000);
      tick();
      chk("s4_out6", 32'(b_if.out_temp), 32'(p2(6'd10, 6'd27)));
      tick();
      chk("s4_out7", 32'(b_if.out_temp), 32'(p2(6'd10, 6'd27)));
      chk("s4_mode7", 32'(b_if.mode), 32'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
